// File: rtl/calc_key_fsm_if.sv
// Keypad-to-display bus for calc_key_fsm: scanner strobe/code in, result status out.
// rem_value exists only when CALC_REM_EN is defined.
interface calc_key_fsm_if #(
   parameter int OPW  = 14,
   parameter int RESW = 28
);
   logic            flag;
   logic [4:0]      real_number;
   logic [RESW-1:0] disp_value;
   logic            disp_neg;
   logic            err;
   logic            busy;
`ifdef CALC_REM_EN
   logic [OPW-1:0]  rem_value;
`endif

   modport master (
      output flag, real_number,
      input  disp_value, disp_neg, err, busy
`ifdef CALC_REM_EN
      , input rem_value
`endif
   );

   modport slave (
      input  flag, real_number,
      output disp_value, disp_neg, err, busy
`ifdef CALC_REM_EN
      , output rem_value
`endif
   );
endinterface

// File: rtl/calc_key_fsm.sv
// Four-function decimal calculator core fed by a keypad scanner; divide is a restoring divider.
// Optional macro CALC_REM_EN adds the rem_value output (divider remainder).
module calc_key_fsm #(
   parameter int DIGITS = 4,
   parameter int OPW    = 14,
   parameter int RESW   = 28
) (
   input logic           clk,
   input logic           rst,
   calc_key_fsm_if.slave bus
);
   localparam int CW  = $clog2(DIGITS + 1);
   localparam int DCW = $clog2(OPW);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DIGITS);
   localparam logic [DCW-1:0]  DIV_END = DCW'(OPW - 1);
   localparam logic [RESW-1:0] MAXV    = RESW'(10**DIGITS - 1);

   typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, DIV, RESULT, ERROR} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   state_t          r_state, w_state_n;
   op_t             r_op, w_op_n, w_kop;
   logic            r_flag_d;
   logic [OPW-1:0]  r_a, w_a_n, r_b, w_b_n, r_rem, w_rem_n, r_quo, w_quo_n;
   logic [CW-1:0]   r_cnt, w_cnt_n;
   logic [DCW-1:0]  r_dcnt, w_dcnt_n;
   logic [RESW-1:0] r_disp, w_disp_n;
   logic            r_neg, w_neg_n, r_chain, w_chain_n;
`ifdef CALC_REM_EN
   logic [OPW-1:0]  r_remv, w_remv_n;
`endif

   logic           w_evt, w_digit, w_opkey, w_eq, w_clr, w_chain_ok;
   logic [3:0]     w_key;
   logic [OPW-1:0] w_acc_a, w_acc_b, w_rem_step, w_quo_step;
   logic [OPW:0]   w_shift, w_trial;

   assign w_evt      = bus.flag & ~r_flag_d & ~bus.real_number[4];
   assign w_key      = bus.real_number[3:0];
   assign w_digit    = w_evt & (w_key <= 4'd9);
   assign w_opkey    = w_evt & (w_key >= 4'd10) & (w_key <= 4'd13);
   assign w_eq       = w_evt & (w_key == 4'd14);
   assign w_clr      = w_evt & (w_key == 4'd15);
   assign w_acc_a    = r_a * OPW'(10) + OPW'(w_key);
   assign w_acc_b    = r_b * OPW'(10) + OPW'(w_key);
   assign w_chain_ok = ~r_neg & (r_disp <= MAXV);

   // Restoring step: shift next dividend bit into the partial remainder, keep it if B fits.
   assign w_shift    = {r_rem, r_quo[OPW-1]};
   assign w_trial    = w_shift - {1'b0, r_b};
   assign w_rem_step = w_trial[OPW] ? w_shift[OPW-1:0] : w_trial[OPW-1:0];
   assign w_quo_step = {r_quo[OPW-2:0], ~w_trial[OPW]};

   // Operator codes 10..13 decode uniquely from their low two bits.
   always_comb begin
      unique case (w_key[1:0])
         2'b10:   w_kop = OP_ADD;
         2'b11:   w_kop = OP_SUB;
         2'b00:   w_kop = OP_MUL;
         default: w_kop = OP_DIV;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ENTER_A;
         r_op     <= OP_ADD;
         r_flag_d <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_cnt    <= '0;
         r_dcnt   <= '0;
         r_disp   <= '0;
         r_neg    <= 1'b0;
         r_chain  <= 1'b0;
`ifdef CALC_REM_EN
         r_remv   <= '0;
`endif
      end else begin
         r_state  <= w_state_n;
         r_op     <= w_op_n;
         r_flag_d <= bus.flag;
         r_a      <= w_a_n;
         r_b      <= w_b_n;
         r_rem    <= w_rem_n;
         r_quo    <= w_quo_n;
         r_cnt    <= w_cnt_n;
         r_dcnt   <= w_dcnt_n;
         r_disp   <= w_disp_n;
         r_neg    <= w_neg_n;
         r_chain  <= w_chain_n;
`ifdef CALC_REM_EN
         r_remv   <= w_remv_n;
`endif
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_op_n    = r_op;
      w_a_n     = r_a;
      w_b_n     = r_b;
      w_rem_n   = r_rem;
      w_quo_n   = r_quo;
      w_cnt_n   = r_cnt;
      w_dcnt_n  = r_dcnt;
      w_disp_n  = r_disp;
      w_neg_n   = r_neg;
      w_chain_n = r_chain;
`ifdef CALC_REM_EN
      w_remv_n  = r_remv;
`endif
      if (w_clr) begin
         w_state_n = ENTER_A;
         w_op_n    = OP_ADD;
         w_a_n     = '0;
         w_b_n     = '0;
         w_rem_n   = '0;
         w_quo_n   = '0;
         w_cnt_n   = '0;
         w_dcnt_n  = '0;
         w_disp_n  = '0;
         w_neg_n   = 1'b0;
         w_chain_n = 1'b0;
`ifdef CALC_REM_EN
         w_remv_n  = '0;
`endif
      end else begin
         unique case (r_state)
            ENTER_A: begin
               if (w_digit && r_cnt != CNT_MAX) begin
                  w_a_n    = w_acc_a;
                  w_cnt_n  = r_cnt + 1'b1;
                  w_disp_n = RESW'(w_acc_a);
               end else if (w_opkey) begin
                  w_op_n    = w_kop;
                  w_cnt_n   = '0;
                  w_state_n = OP_WAIT;
               end
            end
            OP_WAIT: begin
               if (w_opkey) begin
                  w_op_n = w_kop;
               end else if (w_digit) begin
                  w_b_n     = OPW'(w_key);
                  w_cnt_n   = CW'(1);
                  w_disp_n  = RESW'(w_key);
                  w_state_n = ENTER_B;
               end
            end
            ENTER_B: begin
               if (w_digit) begin
                  if (r_cnt != CNT_MAX) begin
                     w_b_n    = w_acc_b;
                     w_cnt_n  = r_cnt + 1'b1;
                     w_disp_n = RESW'(w_acc_b);
                  end
               end else if (w_eq || w_opkey) begin
                  w_chain_n = w_opkey;
                  if (w_opkey) w_op_n = w_kop;
`ifdef CALC_REM_EN
                  w_remv_n  = '0;
`endif
                  w_neg_n   = 1'b0;
                  w_state_n = RESULT;
                  unique case (r_op)
                     OP_ADD: w_disp_n = RESW'(r_a) + RESW'(r_b);
                     OP_SUB: begin
                        w_neg_n  = (r_a < r_b);
                        w_disp_n = (r_a >= r_b) ? RESW'(r_a - r_b) : RESW'(r_b - r_a);
                     end
                     OP_MUL: w_disp_n = RESW'(r_a) * RESW'(r_b);
                     default: begin
                        if (r_b == '0) begin
                           w_state_n = ERROR;
                        end else begin
                           w_rem_n   = '0;
                           w_quo_n   = r_a;
                           w_dcnt_n  = '0;
                           w_state_n = DIV;
                        end
                     end
                  endcase
               end
            end
            DIV: begin
               w_rem_n  = w_rem_step;
               w_quo_n  = w_quo_step;
               w_dcnt_n = r_dcnt + 1'b1;
               if (r_dcnt == DIV_END) begin
                  w_disp_n  = RESW'(w_quo_step);
                  w_state_n = RESULT;
`ifdef CALC_REM_EN
                  w_remv_n  = w_rem_step;
`endif
               end
            end
            RESULT: begin
               // A pending operator-triggered chain resolves before any new key is considered.
               if (r_chain || w_opkey) begin
                  w_chain_n = 1'b0;
                  if (!r_chain) w_op_n = w_kop;
                  if (w_chain_ok) begin
                     w_a_n     = r_disp[OPW-1:0];
                     w_cnt_n   = '0;
                     w_state_n = OP_WAIT;
                  end else begin
                     w_state_n = ERROR;
                  end
               end else if (w_digit) begin
                  w_a_n     = OPW'(w_key);
                  w_cnt_n   = CW'(1);
                  w_disp_n  = RESW'(w_key);
                  w_neg_n   = 1'b0;
                  w_state_n = ENTER_A;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy       = (r_state == DIV);
      bus.err        = (r_state == ERROR);
      bus.disp_value = (r_state == ERROR) ? '0 : r_disp;
      bus.disp_neg   = (r_state == ERROR) ? 1'b0 : r_neg;
`ifdef CALC_REM_EN
      bus.rem_value  = (r_state == RESULT) ? r_remv : '0;
`endif
   end
endmodule

// File: tb/tb_calc_key_fsm.sv
// Scoreboard bench for calc_key_fsm: stimulus queues expected outputs per cycle, a monitor checks them.
// Define CALC_REM_EN to also check rem_value.
module tb_calc_key_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   calc_key_fsm_if #(.OPW(14), .RESW(28)) bus ();

   calc_key_fsm #(.DIGITS(4), .OPW(14), .RESW(28)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned due;
      string       name;
      logic [27:0] disp;
      logic        neg;
      logic        err;
      logic        busy;
      logic [13:0] rem;
   } exp_t;

   exp_t q[$];

   task automatic expect_at(input int unsigned ofs, input string name, input logic [27:0] disp,
                            input logic neg, input logic err, input logic busy, input logic [13:0] rem);
      exp_t e;
      e.due = cyc + ofs; e.name = name; e.disp = disp;
      e.neg = neg; e.err = err; e.busy = busy; e.rem = rem;
      q.push_back(e);
   endtask

   task automatic press(input logic [4:0] k);
      @(posedge clk); #1;
      bus.flag = 1'b1; bus.real_number = k;
      @(posedge clk); #1;
      bus.flag = 1'b0; bus.real_number = 5'd17;
   endtask

   task automatic press_seq(input logic [4:0] ks[$]);
      foreach (ks[i]) press(ks[i]);
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         logic [13:0] rem_act;
         e = q.pop_front();
`ifdef CALC_REM_EN
         rem_act = bus.rem_value;
`else
         rem_act = e.rem;
`endif
         n_cmp++;
         if (e.due != cyc) begin
            n_bad++;
            $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
         end else if (bus.disp_value !== e.disp || bus.disp_neg !== e.neg || bus.err !== e.err ||
                      bus.busy !== e.busy || rem_act !== e.rem) begin
            n_bad++;
            $display("FAIL %s: got disp=%0d neg=%b err=%b busy=%b rem=%0d, want disp=%0d neg=%b err=%b busy=%b rem=%0d",
                     e.name, bus.disp_value, bus.disp_neg, bus.err, bus.busy, rem_act,
                     e.disp, e.neg, e.err, e.busy, e.rem);
         end
      end
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flag = 1'b0;
      bus.real_number = 5'd17;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      expect_at(0, "reset", 28'd0, 0, 0, 0, 14'd0);

      // 12 + 34 = 46
      press_seq('{5'd1, 5'd2});
      expect_at(0, "enter_12", 28'd12, 0, 0, 0, 14'd0);
      press(5'd20);
      expect_at(0, "code_ignored", 28'd12, 0, 0, 0, 14'd0);
      press_seq('{5'd10, 5'd3, 5'd4, 5'd14});
      expect_at(0, "add_46", 28'd46, 0, 0, 0, 14'd0);
      press(5'd15);
      expect_at(0, "clear_after_add", 28'd0, 0, 0, 0, 14'd0);

      // 5 - 9 = -4
      press_seq('{5'd5, 5'd11, 5'd9, 5'd14});
      expect_at(0, "sub_neg4", 28'd4, 1, 0, 0, 14'd0);
      press(5'd15);

      // 9999 * 9999, fifth digit dropped
      press_seq('{5'd9, 5'd9, 5'd9, 5'd9, 5'd9});
      expect_at(0, "digit_limit", 28'd9999, 0, 0, 0, 14'd0);
      press_seq('{5'd12, 5'd9, 5'd9, 5'd9, 5'd9, 5'd14});
      expect_at(0, "mul_max", 28'd99980001, 0, 0, 0, 14'd0);
      press(5'd15);

      // 7 / 2: 14 busy cycles then quotient 3 remainder 1
      press_seq('{5'd7, 5'd13, 5'd2, 5'd14});
      for (int i = 0; i < 14; i++) expect_at(i, "div_busy", 28'd2, 0, 0, 1, 14'd0);
      expect_at(14, "div_result", 28'd3, 0, 0, 0, 14'd1);
      repeat (16) @(posedge clk);
      #1 press(5'd15);
      expect_at(0, "clear_after_div", 28'd0, 0, 0, 0, 14'd0);

      // 8 / 0 -> error, then clear
      press_seq('{5'd8, 5'd13, 5'd0, 5'd14});
      expect_at(0, "div_zero_err", 28'd0, 0, 1, 0, 14'd0);
      press(5'd9);
      expect_at(0, "err_sticky", 28'd0, 0, 1, 0, 14'd0);
      press(5'd15);
      expect_at(0, "err_cleared", 28'd0, 0, 0, 0, 14'd0);

      // held flag: only one digit accepted
      @(posedge clk); #1;
      bus.flag = 1'b1; bus.real_number = 5'd3;
      repeat (5) @(posedge clk);
      #1 bus.flag = 1'b0; bus.real_number = 5'd17;
      expect_at(0, "held_flag", 28'd3, 0, 0, 0, 14'd0);
      press(5'd14);
      expect_at(0, "eq_ignored_a", 28'd3, 0, 0, 0, 14'd0);
      press(5'd15);

      // operator chaining: 2 + 3 + 4 = 9
      press_seq('{5'd2, 5'd10, 5'd3, 5'd10});
      expect_at(0, "chain_partial", 28'd5, 0, 0, 0, 14'd0);
      press_seq('{5'd4, 5'd14});
      expect_at(0, "chain_9", 28'd9, 0, 0, 0, 14'd0);
      press(5'd15);

      // chaining an out-of-range result: 9999 * 2 + -> error
      press_seq('{5'd9, 5'd9, 5'd9, 5'd9, 5'd12, 5'd2, 5'd10});
      expect_at(0, "chain_result", 28'd19998, 0, 0, 0, 14'd0);
      expect_at(1, "chain_overflow", 28'd0, 0, 1, 0, 14'd0);
      press(5'd15);

      // asynchronous reset mid-divide
      press_seq('{5'd9, 5'd13, 5'd3, 5'd14});
      expect_at(0, "div_started", 28'd3, 0, 0, 1, 14'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      expect_at(0, "async_rst", 28'd0, 0, 0, 0, 14'd0);
      #5 rst = 1'b0;
      expect_at(1, "after_rst", 28'd0, 0, 0, 0, 14'd0);

      repeat (4) @(posedge clk);
      #1;
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: never checked (due cycle %0d)", e.name, e.due);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
